// File: rtl/pipelined_csa_addsub.sv
// Pipelined carry-select adder/subtractor: one operand slice per stage, registered carries between stages.
// Optional signed-overflow output enabled by defining CSA_ADDSUB_OVF_EN.
module pipelined_csa_addsub #(
  parameter int IN_DATAWIDTH  = 16,
  parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
  parameter int NUM_STAGES    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_DATAWIDTH-1:0]  in1,
  input  logic [IN_DATAWIDTH-1:0]  in2,
  input  logic                     cin,
  input  logic                     sub,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OUT_DATAWIDTH-1:0] sum,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef CSA_ADDSUB_OVF_EN
  ,
  output logic                     ovf
`endif
);

  localparam int S  = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
  localparam int W  = IN_DATAWIDTH;
  localparam int SW = W / S;

  if (NUM_STAGES < 1 || (IN_DATAWIDTH % S) != 0) begin : g_bad_cfg
    $fatal(1, "pipelined_csa_addsub: NUM_STAGES must be >= 1 and divide IN_DATAWIDTH");
  end

  // Per-stage state: operands travel with the transaction so stage k sees
  // its slice one cycle after stage k-1 consumed the slice below it.
  logic [W-1:0] a_q [S];
  logic [W-1:0] a_d [S];
  logic [W-1:0] b_q [S];
  logic [W-1:0] b_d [S];
  logic [W-1:0] s_q [S];
  logic [W-1:0] s_d [S];
  logic         c_q [S];
  logic         c_d [S];
  logic         v_q [S];
  logic         v_d [S];

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [W-1:0] src_s;
    logic         src_c;
    logic         src_v;
    logic [SW:0]  p0;
    logic [SW:0]  p1;

    if (k == 0) begin : g_first
      // sub and cin are folded in at acceptance, so later mode changes
      // cannot reach transactions already in flight.
      assign src_a = in1;
      assign src_b = in2 ^ {W{sub}};
      assign src_c = cin;
      assign src_s = '0;
      assign src_v = in_valid;
    end else begin : g_next
      assign src_a = a_q[k-1];
      assign src_b = b_q[k-1];
      assign src_c = c_q[k-1];
      assign src_s = s_q[k-1];
      assign src_v = v_q[k-1];
    end

    assign p0 = {1'b0, src_a[k*SW +: SW]} + {1'b0, src_b[k*SW +: SW]};
    assign p1 = p0 + (SW+1)'(1);

    // NOTE: the whole vector gets a value before the slice overwrite, so
    // every bit is assigned on every pass and no latch is inferred.
    always_comb begin
      s_d[k]              = src_s;
      s_d[k][k*SW +: SW]  = src_c ? p1[SW-1:0] : p0[SW-1:0];
    end

    assign c_d[k] = src_c ? p1[SW] : p0[SW];
    assign a_d[k] = src_a;
    assign b_d[k] = src_b;
    assign v_d[k] = src_v;
  end

  // Reset overrides backpressure so the pipeline can always be flushed.
  assign in_ready  = rst || !v_q[S-1] || out_ready;
  assign out_valid = v_q[S-1];
  assign sum       = OUT_DATAWIDTH'({c_q[S-1], s_q[S-1]});

  // NOTE: state uses non-blocking assignments so every stage samples the
  // previous stage's old value at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared too, not just valids, so sum reads 0 after reset.
      for (int k = 0; k < S; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (in_ready) begin
      for (int k = 0; k < S; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

`ifdef CSA_ADDSUB_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Overflow when both effective operands share a sign the result lacks.
  assign ovf_d = (a_d[S-1][W-1] == b_d[S-1][W-1]) &&
                 (s_d[S-1][W-1] != a_d[S-1][W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_ready) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_csa_addsub.sv
// Directed and scoreboard checks for pipelined_csa_addsub at 8 bits, 2 stages.
module tb_pipelined_csa_addsub;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int OW = W + 1;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          cin;
  logic          sub;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] sum;
  logic          out_valid;
  logic          out_ready;
`ifdef CSA_ADDSUB_OVF_EN
  logic          ovf;
`endif

  pipelined_csa_addsub #(
    .IN_DATAWIDTH (W),
    .OUT_DATAWIDTH(OW),
    .NUM_STAGES   (S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in2      (in2),
    .cin      (cin),
    .sub      (sub),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef CSA_ADDSUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] sum;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [OW-1:0] exp_sum;
  logic          exp_ovf;
  bit            lat_chk;
  bit            last_acc;
  int            cyc;
  int            delivered;
  int            total;
  int            bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic c, input logic s);
    logic [W-1:0] bb;
    bb = s ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + OW'(c);
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic c, input logic s);
    logic [W-1:0] bb;
    logic [OW-1:0] r;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + OW'(c);
    return (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s);
    in1      = a;
    in2      = b;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    exp_sum  = model_sum(a, b, c, s);
    exp_ovf  = model_ovf(a, b, c, s);
  endtask

  // One clock: sample just after the falling edge, score handshakes, advance.
  task automatic step();
    exp_t e;
    #1;
    last_acc = in_valid && in_ready && !rst;
    if (!rst && out_valid && !out_ready && q.size() > 0) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_hold", sum, q[0].sum);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = q.pop_front();
        delivered++;
        check("sum", sum, e.sum);
`ifdef CSA_ADDSUB_OVF_EN
        check("ovf", ovf, e.ovf);
`endif
        if (lat_chk) check("latency", cyc - e.cyc, S);
      end
    end
    if (last_acc) q.push_back('{sum: exp_sum, ovf: exp_ovf, cyc: cyc});
    @(posedge clk);
    cyc++;
    if (rst) q.delete();
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) step();
    check("drain_empty", q.size(), 0);
  endtask

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];

  initial begin
    total = 0; bad = 0; cyc = 0; delivered = 0; lat_chk = 1'b1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
    exp_sum = '0; exp_ovf = 1'b0;

    // Reset with in_valid high: nothing may be accepted.
    @(negedge clk);
    set_op(8'h11, 8'h22, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic add with exact latency.
    out_ready = 1'b1;
    set_op(8'hC8, 8'h64, 1'b0, 1'b0);
    exp_sum = 9'h12C;
    step();
    check("accept_add", last_acc, 1);
    in_valid = 1'b0;
    check("not_early", out_valid, 0);
    step();
    step();
    check("add_delivered", delivered, 1);

    // Subtract, back to back: borrow and no-borrow cases.
    set_op(8'h64, 8'hC8, 1'b1, 1'b1);
    exp_sum = 9'h09C;
    step();
    set_op(8'hC8, 8'h64, 1'b1, 1'b1);
    exp_sum = 9'h164;
    step();
`ifdef CSA_ADDSUB_OVF_EN
    set_op(8'h7F, 8'h01, 1'b0, 1'b0);
    exp_sum = 9'h080; exp_ovf = 1'b1;
    step();
    set_op(8'h80, 8'h01, 1'b1, 1'b1);
    exp_sum = 9'h17F; exp_ovf = 1'b1;
    step();
`endif
    drain();

    // Bubbles interleaved with transactions.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) set_op(8'(8'h30 * i + 8'h0F), 8'(8'hA5 - i), 1'(i / 2), 1'b0);
      else in_valid = 1'b0;
      step();
    end
    drain();

    // Eight back-to-back transactions with a three-cycle output stall.
    lat_chk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
    end
    begin
      int i;
      int start_del;
      i = 0;
      start_del = delivered;
      for (int n = 0; n < 100 && i < 8; n++) begin
        set_op(va[i], vb[i], 1'(i % 3 == 0), 1'(i % 2));
        out_ready = !(n >= 4 && n < 7);
        step();
        if (last_acc) i++;
      end
      check("stall_all_sent", i, 8);
      drain();
      check("stall_delivered", delivered - start_del, 8);
    end
    lat_chk = 1'b1;

    // Reset with two transactions in flight.
    out_ready = 1'b1;
    set_op(8'h12, 8'h34, 1'b0, 1'b0);
    step();
    set_op(8'hF0, 8'h0F, 1'b1, 1'b1);
    step();
    rst = 1'b1; out_ready = 1'b0;
    set_op(8'h55, 8'h55, 1'b0, 1'b0);
    #1;
    check("rst_in_ready_busy", in_ready, 1);
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_sum", sum, 0);
    for (int n = 0; n < 5; n++) step();
    check("rst2_no_stale", q.size(), 0);

    // Alternating add/subtract at full throughput with random operands.
    for (int i = 0; i < 20; i++) begin
      set_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'(i % 2));
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_csa_addsub.md
PIPELINED_CSA_ADDSUB -- requirements
Module: pipelined_csa_addsub

Interface
REQ-001 SHALL have parameter IN_DATAWIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter OUT_DATAWIDTH, default IN_DATAWIDTH+1, result width (carry-out plus sum).
REQ-003 SHALL have parameter NUM_STAGES, default 4, number of pipeline stages; each stage processes IN_DATAWIDTH/NUM_STAGES bits.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in1, input, IN_DATAWIDTH, operand A.
REQ-007 SHALL have port in2, input, IN_DATAWIDTH, operand B.
REQ-008 SHALL have port cin, input, 1, carry-in into bit 0.
REQ-009 SHALL have port sub, input, 1, mode select: 0 = add, 1 = subtract.
REQ-010 SHALL have port in_valid, input, 1, operands valid this cycle.
REQ-011 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-012 SHALL have port sum, output, OUT_DATAWIDTH, result; MSB is carry-out.
REQ-013 SHALL have port out_valid, output, 1, sum valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts sum.

Function
REQ-015 SHALL compute sum = in1 + in2 + cin when sub=0, and sum = in1 + ~in2 + cin when sub=1 (true difference in1-in2 when cin=1; sum MSB=1 means no borrow).
REQ-016 SHALL use carry-select per stage: both carry-in=0 and carry-in=1 partial sums precomputed, selected by the registered carry from the previous stage.
REQ-017 SHALL register the inter-stage carry and skew operand slices so that stage k operates on the slice of the same transaction as stage k-1 one cycle earlier.
REQ-018 SHALL have a latency of exactly NUM_STAGES cycles from an accepted input (in_valid && in_ready) to out_valid with no backpressure.
REQ-019 SHALL accept one transaction per cycle (full throughput) while out_ready is held high.
REQ-020 SHALL drive in_ready = !out_valid || out_ready; the entire pipeline advances only when in_ready is 1, otherwise all stage registers hold.
REQ-021 SHALL carry a per-stage valid bit; bubbles (in_valid=0 when in_ready=1) propagate as invalid slots and never produce out_valid.
REQ-022 SHALL hold sum and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL latch sub and cin with the transaction so that mode changes between back-to-back transactions do not affect in-flight results.
REQ-024 SHALL wrap modulo 2^OUT_DATAWIDTH; no saturation.
REQ-025 SHALL, in simulation only, print an error and terminate if NUM_STAGES < 1 or IN_DATAWIDTH is not a multiple of NUM_STAGES.

Reset
REQ-026 SHALL on rst=1 at a clock edge clear all stage valid bits, carries and data registers; sum=0, out_valid=0 the following cycle.
REQ-027 SHALL discard all in-flight transactions on reset; in_ready SHALL be 1 during and after reset.
REQ-028 SHALL ignore in_valid in any cycle where rst=1.

Configuration
REQ-029 SHALL, when macro CSA_ADDSUB_OVF_EN is defined, add output port ovf (1 bit, pipelined alongside sum, reset 0) flagging two's-complement signed overflow of the IN_DATAWIDTH-bit result for the operation actually performed.
REQ-030 SHALL, when CSA_ADDSUB_OVF_EN is undefined, omit port ovf and all its logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover, IN_DATAWIDTH=8, NUM_STAGES=2, sub=0, cin=0, in1=8'hC8, in2=8'h64 -> sum=9'h12C, out_valid exactly 2 cycles after acceptance.
REQ-032 SHALL cover sub=1, cin=1, in1=8'h64, in2=8'hC8 -> sum=9'h09C (MSB 0 = borrow); in1=8'hC8, in2=8'h64 -> sum=9'h164.
REQ-033 SHALL cover 8 back-to-back transactions with out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, sum held, all 8 results delivered in order with none lost or duplicated.
REQ-034 SHALL cover rst asserted with 2 transactions in flight -> out_valid=0, sum=0 next cycle; no stale result emerges afterwards.
REQ-035 SHALL cover, with CSA_ADDSUB_OVF_EN, sub=0, in1=8'h7F, in2=8'h01, cin=0 -> sum=9'h080, ovf=1; sub=1, cin=1, in1=8'h80, in2=8'h01 -> sum=9'h17F, ovf=1.
REQ-036 SHALL cover alternating sub=0/1 every cycle with random operands at full throughput -> every result matches REQ-015 against a reference model.
